// File: rtl/fifo_drain_scheduler_pkg.sv
// Shared types and default sizing for the FIFO drain scheduler.
package fifo_sched_pkg;

    typedef enum logic {
        IDLE,
        SERVE
    } sched_state_t;

    localparam int N_CH_DEF      = 4;
    localparam int MAX_BURST_DEF = 4;
    localparam int DATA_W_DEF    = 8;

endpackage

// File: rtl/fifo_drain_scheduler_if.sv
// Output stream of the drain scheduler: tagged word plus valid/ready handshake.
interface fifo_drain_scheduler_if
    import fifo_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH_W   = $clog2(N_CH_DEF)
);
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_ch,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_ch,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set req bit strictly after 'last', wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    // Offset N wraps back onto 'last' itself, so a lone requester is re-granted.
    always_comb begin
        int cand;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_valid && req[cand[IW-1:0]]) begin
                gnt_idx   = cand[IW-1:0];
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_drain_scheduler.sv
// Drains N_CH FWFT FIFOs round-robin, MAX_BURST words per grant, into one registered tagged stream.
module fifo_drain_scheduler
    import fifo_sched_pkg::*;
#(
    parameter  int N_CH      = N_CH_DEF,
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int CH_W      = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        ch_empty,
    input  logic [N_CH*DATA_W-1:0] ch_dout,
    output logic [N_CH-1:0]        ch_rd_en,
    fifo_drain_scheduler_if.master out_if,
    output logic                   busy
);

    localparam int              BC_W     = $clog2(MAX_BURST + 1);
    localparam logic [CH_W-1:0] LAST_RST = CH_W'(N_CH - 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(MAX_BURST - 1);

    sched_state_t      state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   last_grant;
    logic [BC_W-1:0]   burst_cnt;
    logic [DATA_W-1:0] out_data_q;
    logic [CH_W-1:0]   out_ch_q;
    logic              out_valid_q;

    logic [DATA_W-1:0] ch_word [N_CH];
    logic [CH_W-1:0]   arb_idx;
    logic              arb_valid;
    logic              can_load;
    logic              pop;

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_word[i] = ch_dout[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N(N_CH)
    ) u_arb (
        .req       (~ch_empty),
        .last      (last_grant),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign can_load = !out_valid_q || out_if.out_ready;
    assign pop      = (state == SERVE) && can_load && !ch_empty[grant];

    always_comb begin
        ch_rd_en        = '0;
        ch_rd_en[grant] = pop;
    end

    // One block owns the FSM, burst counter and output register; a pop and an output load are the same event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= LAST_RST;
            burst_cnt   <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (pop) begin
                out_data_q  <= ch_word[grant];
                out_ch_q    <= grant;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_if.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant     <= arb_idx;
                        burst_cnt <= '0;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (can_load) begin
                        if (ch_empty[grant]) begin
                            state      <= IDLE;
                            last_grant <= grant;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                            if (burst_cnt == BC_LAST) begin
                                state      <= IDLE;
                                last_grant <= grant;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_ch    = out_ch_q;
    assign out_if.out_valid = out_valid_q;
    assign busy             = (state == SERVE);

    a_pop_safe: assert property (@(posedge clk) disable iff (reset)
        ((ch_rd_en & ch_empty) == '0) && $onehot0(ch_rd_en));

endmodule
